// File: rtl/nic_endpoint.sv
// PE-side network interface: a tx FIFO that injects into the router on the
// matching VC phase, and an rx FIFO the PE drains through a 4-entry register map.
module nic_endpoint #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_si,
  input  logic                  net_ri,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity,
  input  logic                  net_so,
  output logic                  net_ro,
  input  logic [DATA_WIDTH-1:0] net_di
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  localparam logic [1:0] ADDR_RX_POP  = 2'b00;
  localparam logic [1:0] ADDR_RX_STAT = 2'b01;
  localparam logic [1:0] ADDR_TX_PUSH = 2'b10;
  localparam logic [1:0] ADDR_TX_STAT = 2'b11;

  logic [DATA_WIDTH-1:0] r_tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rx_mem [DEPTH];
  logic [AW-1:0]         r_tx_rd, r_tx_wr, r_rx_rd, r_rx_wr;
  logic [CW-1:0]         r_tx_cnt, r_rx_cnt;
  logic [DATA_WIDTH-1:0] r_d_out;

  logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic                  w_rd, w_wr;
  logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [DATA_WIDTH-1:0] w_tx_head, w_rx_head, w_rd_data;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  // Status word: bit0 full, bit1 empty, bits[15:8] occupancy.
  function automatic logic [DATA_WIDTH-1:0] status(input logic [CW-1:0] cnt);
    logic [15:0] s;
    s = {8'(cnt), 6'd0, (cnt == '0), (cnt == FULL_CNT)};
    return DATA_WIDTH'(s);
  endfunction

  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_tx_head  = r_tx_mem[r_tx_rd];
  assign w_rx_head  = r_rx_mem[r_rx_rd];

  assign w_rd = nicEn & ~nicWrEn;
  assign w_wr = nicEn & nicWrEn;

  // Inject only when the router phase differs from the head packet's VC bit.
  assign net_si = ~w_tx_empty & net_ri & (net_polarity != w_tx_head[DATA_WIDTH-1]);
  assign net_do = w_tx_head;
  assign net_ro = ~w_rx_full;

  assign w_tx_push = w_wr & (addr == ADDR_TX_PUSH) & ~w_tx_full;
  assign w_tx_pop  = net_si;
  assign w_rx_push = net_so & net_ro;
  assign w_rx_pop  = w_rd & (addr == ADDR_RX_POP) & ~w_rx_empty;

  always_comb begin
    w_rd_data = '0;
    case (addr)
      ADDR_RX_POP:  w_rd_data = w_rx_empty ? '0 : w_rx_head;
      ADDR_RX_STAT: w_rd_data = status(r_rx_cnt);
      ADDR_TX_PUSH: w_rd_data = '0;
      ADDR_TX_STAT: w_rd_data = status(r_tx_cnt);
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_tx_mem[i] <= '0;
    end else if (w_tx_push) begin
      r_tx_mem[r_tx_wr] <= d_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_rd  <= '0;
      r_tx_wr  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= ptr_inc(r_tx_wr);
      if (w_tx_pop)  r_tx_rd <= ptr_inc(r_tx_rd);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_rx_mem[i] <= '0;
    end else if (w_rx_push) begin
      r_rx_mem[r_rx_wr] <= net_di;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_rd  <= '0;
      r_rx_wr  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= ptr_inc(r_rx_wr);
      if (w_rx_pop)  r_rx_rd <= ptr_inc(r_rx_rd);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_d_out <= '0;
    else if (w_rd) r_d_out <= w_rd_data;
  end

  assign d_out = r_d_out;

endmodule
